// File: rtl/mem_access_arbiter_if.sv
// Bundle of fetch port, data port and memory port signals for mem_access_arbiter.
// The arbiter takes the slave side; requesters and the memory model take the master side.
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [31:0]       if_rdata;
    logic              if_err;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [1:0]        dm_size;
    logic              dm_unsigned;
    logic [63:0]       dm_wdata;
    logic              dm_ready;
    logic [63:0]       dm_rdata;
    logic              dm_err;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wdata;
    logic [63:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_size, dm_unsigned, dm_wdata,
               mem_rdata,
        output if_ready, if_rdata, if_err, dm_ready, dm_rdata, dm_err,
               mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_size, dm_unsigned, dm_wdata,
               mem_rdata,
        input  if_ready, if_rdata, if_err, dm_ready, dm_rdata, dm_err,
               mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin sequencer sharing one big-endian 64-bit memory between fetch and data ports,
// with sized/sign-extended loads and read-modify-write sub-doubleword stores.
module mem_access_arbiter #(
    parameter int MEM_BYTES = 2048,
    parameter int ADDR_W    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mem_access_arbiter_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, ST_RD, ST_WR, DONE} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;        // 0: data wins a tie, 1: fetch wins
    logic              gnt_dm_q, gnt_dm_d;
    logic              uns_q, uns_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wbuf_q, wbuf_d;
    logic              err_q, err_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [63:0]       dm_rdata_q, dm_rdata_d;

    logic              pick_dm;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W:0]   req_end;
    logic              in_range;
    logic [63:0]       ld_ext;
    logic [63:0]       merged;

    assign pick_dm  = bus.dm_req & (~bus.if_req | ~ptr_q);
    assign req_addr = pick_dm ? bus.dm_addr : bus.if_addr;
    // One extra bit so addresses near the top of the space cannot wrap into range.
    assign req_end  = {1'b0, req_addr} + (ADDR_W+1)'(8);
    assign in_range = req_end <= (ADDR_W+1)'(MEM_BYTES);

    always_comb begin
        ld_ext = bus.mem_rdata;
        case (size_q)
            2'd0:    ld_ext = {{56{bus.mem_rdata[63] & ~uns_q}}, bus.mem_rdata[63:56]};
            2'd1:    ld_ext = {{48{bus.mem_rdata[63] & ~uns_q}}, bus.mem_rdata[63:48]};
            2'd2:    ld_ext = {{32{bus.mem_rdata[63] & ~uns_q}}, bus.mem_rdata[63:32]};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    // New bytes land at the lowest address, which is the most significant end.
    always_comb begin
        merged = wbuf_q;
        case (size_q)
            2'd0:    merged = {wbuf_q[7:0],  bus.mem_rdata[55:0]};
            2'd1:    merged = {wbuf_q[15:0], bus.mem_rdata[47:0]};
            2'd2:    merged = {wbuf_q[31:0], bus.mem_rdata[31:0]};
            default: merged = wbuf_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_dm_d   = gnt_dm_q;
        uns_d      = uns_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wbuf_d     = wbuf_q;
        err_d      = err_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    // Pointer only moves when both ports contend.
                    if (bus.if_req && bus.dm_req) ptr_d = pick_dm;
                    gnt_dm_d = pick_dm;
                    addr_d   = req_addr;
                    size_d   = bus.dm_size;
                    uns_d    = bus.dm_unsigned;
                    wbuf_d   = bus.dm_wdata;
                    err_d    = ~in_range;
                    if (!in_range) begin
                        state_d = DONE;
                        if (pick_dm) dm_rdata_d = '0;
                        else         if_rdata_d = '0;
                    end else if (!pick_dm) begin
                        state_d = FETCH;
                    end else if (!bus.dm_we) begin
                        state_d = LOAD;
                    end else if (bus.dm_size == 2'd3) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            FETCH: begin
                if_rdata_d = bus.mem_rdata[63:32];
                state_d    = DONE;
            end
            LOAD: begin
                dm_rdata_d = ld_ext;
                state_d    = DONE;
            end
            ST_RD: begin
                wbuf_d  = merged;
                state_d = ST_WR;
            end
            ST_WR:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            gnt_dm_q   <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= '0;
            wbuf_q     <= '0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_dm_q   <= gnt_dm_d;
            uns_q      <= uns_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wbuf_q     <= wbuf_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.if_ready  = (state_q == DONE) & ~gnt_dm_q;
    assign bus.dm_ready  = (state_q == DONE) &  gnt_dm_q;
    assign bus.if_err    = bus.if_ready & err_q;
    assign bus.dm_err    = bus.dm_ready & err_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.mem_read  = state_q inside {FETCH, LOAD, ST_RD};
    // Gating by rst_n keeps a reset landing mid-store from committing the write.
    assign bus.mem_write = (state_q == ST_WR) & rst_n;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wbuf_q;
endmodule
